// File: rtl/ucsbece154b_bpred_gshare_pkg.sv
// Shared definitions for the gshare branch predictor: default sizing,
// PHT counter encodings and the BTB field-width helpers.
package ucsbece154b_bpred_gshare_pkg;

   localparam int NBITS_DEF = 32;
   localparam int IDX_W_DEF = 5;
   localparam int GHR_W_DEF = 5;
   localparam int CNT_W     = 32;

   // 2-bit saturating direction counter; bit [1] is the predicted direction.
   typedef enum logic [1:0] {
      PHT_SNT = 2'b00,
      PHT_WNT = 2'b01,
      PHT_WT  = 2'b10,
      PHT_ST  = 2'b11
   } pht_state_e;

   localparam pht_state_e PHT_RESET = PHT_WNT;

   // BTB tag covers everything above the index and the word-offset bits.
   function automatic int btb_tag_w(input int nbits, input int idx_w);
      return nbits - idx_w - 2;
   endfunction

   function automatic int btb_depth(input int idx_w);
      return 1 << idx_w;
   endfunction

   // Saturating step of a direction counter toward the resolved outcome.
   function automatic pht_state_e pht_next(input pht_state_e cur, input logic taken);
      pht_state_e nxt;
      nxt = cur;
      if (taken) begin
         case (cur)
            PHT_SNT: nxt = PHT_WNT;
            PHT_WNT: nxt = PHT_WT;
            PHT_WT:  nxt = PHT_ST;
            PHT_ST:  nxt = PHT_ST;
            default: nxt = cur;
         endcase
      end else begin
         case (cur)
            PHT_ST:  nxt = PHT_WT;
            PHT_WT:  nxt = PHT_WNT;
            PHT_WNT: nxt = PHT_SNT;
            PHT_SNT: nxt = PHT_SNT;
            default: nxt = cur;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ucsbece154b_bpred_gshare_if.sv
// Fetch-lookup and execute-update bundle between the datapath (master)
// and the predictor (slave). Signal names keep the datapath's _i/_o view.
interface ucsbece154b_bpred_gshare_if #(
   parameter int NBITS = 32,
   parameter int IDX_W = 5
) ();

   // fetch-side lookup
   logic [NBITS-1:0] pc_f_i;
   logic             predict_taken_o;
   logic [NBITS-1:0] target_o;
   logic [IDX_W-1:0] pht_index_o;

   // execute-side resolution
   logic             upd_valid_i;
   logic             upd_is_branch_i;
   logic             upd_taken_i;
   logic [NBITS-1:0] upd_pc_i;
   logic [NBITS-1:0] upd_target_i;
   logic [IDX_W-1:0] upd_pht_index_i;
   logic             upd_mispredict_i;

   // statistics
   logic [31:0]      branch_count_o;
   logic [31:0]      mispredict_count_o;

   modport master (
      output pc_f_i,
      output upd_valid_i, upd_is_branch_i, upd_taken_i,
      output upd_pc_i, upd_target_i, upd_pht_index_i, upd_mispredict_i,
      input  predict_taken_o, target_o, pht_index_o,
      input  branch_count_o, mispredict_count_o
   );

   modport slave (
      input  pc_f_i,
      input  upd_valid_i, upd_is_branch_i, upd_taken_i,
      input  upd_pc_i, upd_target_i, upd_pht_index_i, upd_mispredict_i,
      output predict_taken_o, target_o, pht_index_o,
      output branch_count_o, mispredict_count_o
   );

endinterface

// File: rtl/ucsbece154b_btb.sv
// Direct-mapped tagged branch target buffer. One combinational read port
// for fetch, one clocked write port for resolution. Only the valid bits are
// reset; tag/target/is_jump of an invalid entry are never observed.
module ucsbece154b_btb
   import ucsbece154b_bpred_gshare_pkg::*;
#(
   parameter int NBITS = NBITS_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int TAG_W = btb_tag_w(NBITS, IDX_W)
) (
   input  logic             clk,
   input  logic             reset,

   input  logic [IDX_W-1:0] i_rd_idx,
   input  logic [TAG_W-1:0] i_rd_tag,
   output logic             o_rd_hit,
   output logic [NBITS-1:0] o_rd_target,
   output logic             o_rd_is_jump,

   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0] i_wr_tag,
   input  logic [NBITS-1:0] i_wr_target,
   input  logic             i_wr_is_jump
);

   localparam int DEPTH = btb_depth(IDX_W);

   logic [DEPTH-1:0] r_valid;
   logic [TAG_W-1:0] r_tag     [DEPTH];
   logic [NBITS-1:0] r_target  [DEPTH];
   logic             r_is_jump [DEPTH];

   // Valid bits: cleared asynchronously, set by any write to the entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   // Payload: plain storage, the later write to an index always wins.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]     <= i_wr_tag;
         r_target[i_wr_idx]  <= i_wr_target;
         r_is_jump[i_wr_idx] <= i_wr_is_jump;
      end
   end

   // Read path: pre-write contents, no bypass from the write port.
   always_comb begin
      o_rd_hit     = r_valid[i_rd_idx] & (r_tag[i_rd_idx] == i_rd_tag);
      o_rd_target  = r_target[i_rd_idx];
      o_rd_is_jump = r_is_jump[i_rd_idx];
   end

endmodule

// File: rtl/ucsbece154b_bpred_gshare.sv
// Gshare predictor: BTB (sub-module) plus PHT of 2-bit counters indexed by
// PC xor global history. Lookup is combinational on the fetch PC; state
// changes only on resolved branches/jumps, so the GHR is non-speculative.
module ucsbece154b_bpred_gshare
   import ucsbece154b_bpred_gshare_pkg::*;
#(
   parameter int NBITS = NBITS_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int GHR_W = GHR_W_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   ucsbece154b_bpred_gshare_if.slave    bp
);

   localparam int TAG_W = btb_tag_w(NBITS, IDX_W);
   localparam int DEPTH = btb_depth(IDX_W);

   pht_state_e       r_pht [DEPTH];
   logic [GHR_W-1:0] r_ghr;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_mispredict_cnt;

   logic [IDX_W-1:0] w_f_idx;
   logic [TAG_W-1:0] w_f_tag;
   logic [IDX_W-1:0] w_ghr_ext;
   logic [IDX_W-1:0] w_pht_idx;
   pht_state_e       w_pht_cnt;
   logic             w_btb_hit;
   logic [NBITS-1:0] w_btb_target;
   logic             w_btb_is_jump;
   logic             w_predict;

   logic [IDX_W-1:0] w_u_idx;
   logic [TAG_W-1:0] w_u_tag;
   logic             w_upd_branch;
   logic             w_upd_jump;
   logic             w_btb_we;

   // Word-offset bits of both PCs carry no information for this predictor.
   logic             w_unused_pc_lsbs;
   assign w_unused_pc_lsbs = ^{bp.pc_f_i[1:0], bp.upd_pc_i[1:0]};

   // Fetch-side address split and gshare index; history is right-aligned.
   always_comb begin
      w_f_idx   = bp.pc_f_i[IDX_W+1:2];
      w_f_tag   = bp.pc_f_i[NBITS-1:IDX_W+2];
      w_ghr_ext = IDX_W'(r_ghr);
      w_pht_idx = w_f_idx ^ w_ghr_ext;
      w_pht_cnt = r_pht[w_pht_idx];
   end

   // Resolution-side decode. Not-taken branches never allocate in the BTB,
   // and a taken branch over a jump entry clears its is_jump flag.
   always_comb begin
      w_u_idx      = bp.upd_pc_i[IDX_W+1:2];
      w_u_tag      = bp.upd_pc_i[NBITS-1:IDX_W+2];
      w_upd_branch = bp.upd_valid_i & bp.upd_is_branch_i;
      w_upd_jump   = bp.upd_valid_i & ~bp.upd_is_branch_i;
      w_btb_we     = w_upd_jump | (w_upd_branch & bp.upd_taken_i);
   end

   ucsbece154b_btb #(
      .NBITS (NBITS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_btb (
      .clk          (clk),
      .reset        (reset),
      .i_rd_idx     (w_f_idx),
      .i_rd_tag     (w_f_tag),
      .o_rd_hit     (w_btb_hit),
      .o_rd_target  (w_btb_target),
      .o_rd_is_jump (w_btb_is_jump),
      .i_wr_en      (w_btb_we),
      .i_wr_idx     (w_u_idx),
      .i_wr_tag     (w_u_tag),
      .i_wr_target  (bp.upd_target_i),
      .i_wr_is_jump (w_upd_jump)
   );

   // Prediction: jumps always redirect on a hit, branches follow the PHT.
   always_comb begin
      w_predict          = w_btb_hit & (w_btb_is_jump | w_pht_cnt[1]);
      bp.predict_taken_o = w_predict;
      bp.target_o        = w_predict ? w_btb_target : '0;
      bp.pht_index_o     = w_pht_idx;
   end

   // PHT: train the counter selected at fetch time on each resolved branch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pht[i] <= PHT_RESET;
         end
      end else if (w_upd_branch) begin
         r_pht[bp.upd_pht_index_i] <= pht_next(r_pht[bp.upd_pht_index_i], bp.upd_taken_i);
      end
   end

   // GHR: shift in the resolved direction of conditional branches only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ghr <= '0;
      end else if (w_upd_branch) begin
         r_ghr <= {r_ghr[GHR_W-2:0], bp.upd_taken_i};
      end
   end

   // Statistics counters, free-running and wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else if (bp.upd_valid_i) begin
         if (bp.upd_is_branch_i) begin
            r_branch_cnt <= r_branch_cnt + 1'b1;
         end
         if (bp.upd_mispredict_i) begin
            r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
         end
      end
   end

   // Expose the statistics.
   always_comb begin
      bp.branch_count_o     = r_branch_cnt;
      bp.mispredict_count_o = r_mispredict_cnt;
   end

endmodule

// File: tb/tb_ucsbece154b_bpred_gshare.sv
// Directed bench for the gshare predictor. Stimulus pushes the expected
// lookup response for the cycle it drives; a monitor on the falling edge
// pops and compares, so lookups always see pre-update state.
module tb_ucsbece154b_bpred_gshare;

   logic clk;
   logic reset;

   ucsbece154b_bpred_gshare_if #(.NBITS(32), .IDX_W(5)) bpif ();

   ucsbece154b_bpred_gshare #(.NBITS(32), .IDX_W(5), .GHR_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bpif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        pt;
      logic [31:0] tgt;
      logic [4:0]  idx;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic void chk(input string nm, input string fld,
                               input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, expv);
      end
   endfunction

   // Monitor: compare one expectation per falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         m_e = sb_q.pop_front();
         chk(m_e.name, "predict_taken", {31'd0, bpif.predict_taken_o}, {31'd0, m_e.pt});
         chk(m_e.name, "target",        bpif.target_o,                 m_e.tgt);
         chk(m_e.name, "pht_index",     {27'd0, bpif.pht_index_o},     {27'd0, m_e.idx});
         chk(m_e.name, "branch_count",  bpif.branch_count_o,           m_e.bc);
         chk(m_e.name, "mispred_count", bpif.mispredict_count_o,       m_e.mc);
      end
   end

   function automatic void push(input string nm, input logic pt, input logic [31:0] tgt,
                                input logic [4:0] idx, input logic [31:0] bc,
                                input logic [31:0] mc);
      exp_t e;
      e.name = nm; e.pt = pt; e.tgt = tgt; e.idx = idx; e.bc = bc; e.mc = mc;
      sb_q.push_back(e);
   endfunction

   task automatic drive(input logic [31:0] pc, input logic uv, input logic ub,
                        input logic ut, input logic [31:0] upc, input logic [31:0] utgt,
                        input logic [4:0] uidx, input logic umis);
      bpif.pc_f_i           = pc;
      bpif.upd_valid_i      = uv;
      bpif.upd_is_branch_i  = ub;
      bpif.upd_taken_i      = ut;
      bpif.upd_pc_i         = upc;
      bpif.upd_target_i     = utgt;
      bpif.upd_pht_index_i  = uidx;
      bpif.upd_mispredict_i = umis;
   endtask

   // One cycle: drive lookup + optional update, expect the pre-update response.
   task automatic step(input string nm, input logic [31:0] pc, input logic uv,
                       input logic ub, input logic ut, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic [4:0] uidx, input logic umis,
                       input logic ept, input logic [31:0] etgt, input logic [4:0] eidx,
                       input logic [31:0] ebc, input logic [31:0] emc);
      @(posedge clk);
      #1;
      drive(pc, uv, ub, ut, upc, utgt, uidx, umis);
      push(nm, ept, etgt, eidx, ebc, emc);
   endtask

   task automatic look(input string nm, input logic [31:0] pc, input logic ept,
                       input logic [31:0] etgt, input logic [4:0] eidx,
                       input logic [31:0] ebc, input logic [31:0] emc);
      step(nm, pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0, ept, etgt, eidx, ebc, emc);
   endtask

   logic [4:0] t_idx [5] = '{5'h17, 5'h1F, 5'h0F, 5'h0F, 5'h0F};
   logic [4:0] n_idx [4] = '{5'h0E, 5'h0C, 5'h08, 5'h00};

   initial begin
      reset = 1'b1;
      drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
      push("reset_state", 1'b0, 32'h0, 5'h10, 32'd0, 32'd0);
      #12;
      reset = 1'b0;

      look("reset_lookup", 32'h40, 1'b0, 32'h0, 5'h10, 0, 0);
      // jump allocation, same-cycle lookup still misses
      step("jump_wr", 32'h40, 1, 0, 0, 32'h40, 32'h100, 5'h00, 1,  1'b0, 32'h0, 5'h10, 0, 0);
      look("jump_hit", 32'h40, 1'b1, 32'h100, 5'h10, 0, 1);
      // taken branch: PHT[0]->10, GHR->00001
      step("br_t_80", 32'h40, 1, 1, 1, 32'h80, 32'h20, 5'h00, 1,  1'b1, 32'h100, 5'h10, 0, 1);
      look("br_hit_weak_nt", 32'h80, 1'b0, 32'h0, 5'h01, 1, 2);
      // allocate branch entries at BTB idx 3 and 0x1D (train PHT[7])
      step("br_t_0c", 32'h40, 1, 1, 1, 32'h0C, 32'h444, 5'h07, 0, 1'b1, 32'h100, 5'h11, 1, 2);
      step("br_t_74", 32'h40, 1, 1, 1, 32'h74, 32'h555, 5'h07, 1, 1'b1, 32'h100, 5'h13, 2, 2);
      // five taken on PHT[3]
      for (int i = 0; i < 5; i++) begin
         step("taken_idx3", 32'h40, 1, 1, 1, 32'h70, 32'h700, 5'h03, 0,
              1'b1, 32'h100, t_idx[i], 32'(3 + i), 3);
      end
      look("sat_hi", 32'h70, 1'b1, 32'h700, 5'h03, 8, 3);
      step("nt_1", 32'h70, 1, 1, 0, 32'h70, 32'h700, 5'h03, 1, 1'b1, 32'h700, 5'h03, 8, 3);
      look("after_one_nt", 32'h74, 1'b1, 32'h555, 5'h03, 9, 4);
      for (int i = 0; i < 4; i++) begin
         step("nt_more", 32'h40, 1, 1, 0, 32'h70, 32'h700, 5'h03, 0,
              1'b1, 32'h100, n_idx[i], 32'(9 + i), 4);
      end
      look("sat_lo", 32'h0C, 1'b0, 32'h0, 5'h03, 13, 4);
      look("pht0_taken", 32'h80, 1'b1, 32'h20, 5'h00, 13, 4);
      // same-cycle overwrite: old target this cycle, new one next
      step("jump_rewr", 32'h40, 1, 0, 0, 32'h40, 32'h200, 5'h00, 0, 1'b1, 32'h100, 5'h10, 13, 4);
      look("jump_new_tgt", 32'h40, 1'b1, 32'h200, 5'h10, 13, 4);
      look("pc_lsbs_ignored", 32'h43, 1'b1, 32'h200, 5'h10, 13, 4);
      look("alias_tag_miss", 32'hC0, 1'b0, 32'h0, 5'h10, 13, 4);
      // branch overwrites jump entry at the aliasing index
      step("alias_br_wr", 32'h40, 1, 1, 1, 32'hC0, 32'h999, 5'h1F, 0, 1'b1, 32'h200, 5'h10, 13, 4);
      look("old_tag_miss", 32'h40, 1'b0, 32'h0, 5'h11, 14, 4);
      look("is_jump_cleared", 32'hC0, 1'b0, 32'h0, 5'h11, 14, 4);
      // update fields without valid are ignored
      step("upd_invalid", 32'h0C, 0, 0, 0, 32'h0C, 32'hDEAD, 5'h03, 1, 1'b0, 32'h0, 5'h02, 14, 4);
      look("upd_invalid_chk", 32'h0C, 1'b0, 32'h0, 5'h02, 14, 4);

      // asynchronous reset between edges
      @(posedge clk);
      #1;
      drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
      #2;
      reset = 1'b1;
      push("mid_reset", 1'b0, 32'h0, 5'h10, 0, 0);
      // update presented as reset drops is taken on the next edge
      @(posedge clk);
      #1;
      drive(32'h40, 1'b1, 1'b0, 1'b0, 32'h40, 32'h123, 5'h0, 1'b0);
      #2;
      reset = 1'b0;
      push("reset_release", 1'b0, 32'h0, 5'h10, 0, 0);
      look("post_reset_upd", 32'h40, 1'b1, 32'h123, 5'h10, 0, 0);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ucsbece154b_bpred_gshare.md
Name: ucsbece154b_bpred_gshare

Overview:
Gshare branch predictor that answers the datapath's fetch-stage prediction requests and absorbs its execute-stage resolution writes. It holds a direct-mapped tagged BTB, a PHT of 2-bit saturating counters and a global history register (GHR). It returns taken/target/PHT-index combinationally for the fetch PC. It updates its state on the clock edge when the datapath reports a resolved branch or jump.

Parameters:
NBITS, 32, address/data width
IDX_W, 5, log2 entries of BTB and PHT (32 entries)
GHR_W, 5, history length; must be <= IDX_W; right-aligned and XORed into the index

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
pc_f_i  in  NBITS  fetch PC
predict_taken_o  out  1  predict redirect this cycle
target_o  out  NBITS  predicted target, valid when predict_taken_o=1
pht_index_o  out  IDX_W  PHT index used; datapath pipes it to EX
upd_valid_i  in  1  a branch/jump resolved in EX this cycle
upd_is_branch_i  in  1  1=conditional branch, 0=jal/jalr
upd_taken_i  in  1  actual direction; ignored for jumps
upd_pc_i  in  NBITS  PC of resolved instruction
upd_target_i  in  NBITS  resolved target
upd_pht_index_i  in  IDX_W  index carried from fetch
upd_mispredict_i  in  1  datapath flagged redirect/misprediction
branch_count_o  out  32  resolved conditional branches
mispredict_count_o  out  32  resolved mispredictions

Behaviour:
Reset (async, immediate):
- All BTB valid bits = 0; BTB tag and target contents are don't-care.
- All PHT counters = 2'b01 (weakly not-taken).
- GHR = 0; both counters = 0.
- Resulting outputs: predict_taken_o = 0, target_o = 0, pht_index_o = pc_f_i[IDX_W+1:2] ^ 0.

Lookup (combinational, zero latency):
- BTB index = pc_f_i[IDX_W+1:2]; tag = pc_f_i[NBITS-1:IDX_W+2].
- pht_index_o = pc_f_i[IDX_W+1:2] ^ {zeros, GHR}.
- hit = valid & (tag match).
- predict_taken_o = hit & (entry.is_jump | PHT[pht_index_o][1]).
- target_o = predict_taken_o ? entry.target : 0.

Update (posedge, only when upd_valid_i=1):
- Jump (upd_is_branch_i=0):
  - Write the BTB entry at upd_pc_i index: valid=1, tag, target=upd_target_i, is_jump=1.
  - PHT and GHR are unchanged.
- Branch taken:
  - PHT[upd_pht_index_i] increments, saturating at 11.
  - Write the BTB entry with is_jump=0.
  - GHR <= {GHR[GHR_W-2:0],1}.
- Branch not taken:
  - PHT[upd_pht_index_i] decrements, saturating at 00.
  - BTB is not written.
  - GHR <= {GHR[GHR_W-2:0],0}.
- Counters:
  - branch_count_o increments on every branch update.
  - mispredict_count_o increments when upd_mispredict_i=1, for branch or jump.
  - Both wrap modulo 2^32.
- upd_* inputs are ignored when upd_valid_i=0.

Boundary rules:
- Lookup and update in the same cycle: the lookup sees pre-update state; the new state is visible the next cycle. There is no bypass.
- Two PCs aliasing the same BTB index: the later write overwrites; a tag mismatch means no prediction.
- A BTB entry previously marked is_jump is overwritten by a branch update at the same index. is_jump is cleared in that case.
- GHR is non-speculative; mispredictions do not restore it, because it only changes at resolution.
- pc_f_i bits [1:0] are ignored.
- Reset asserted mid-operation: all state clears immediately regardless of clk. An update presented in the cycle reset deasserts is honoured on the next edge.

Decomposition:
Shared package/defines:
- PHT counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the PHT reset value.
- BTB entry field widths, derived from NBITS/IDX_W.
- Instruction opcodes stay in the existing defines file; this block does not decode opcodes.

Sub-module:
- One natural sub-module, ucsbece154b_btb: the tagged direct-mapped array with valid bits and combinational read.
- PHT, GHR and the counters live in the top.

Test Plan:
- Reset, then pc_f_i=0x00000040 -> predict_taken_o=0, target_o=0, pht_index_o=0x10, both counters 0.
- Jump update pc=0x40, target=0x100; next cycle pc_f_i=0x40 -> predict_taken_o=1, target_o=0x100; GHR and branch_count_o unchanged.
- Taken-branch update pc=0x80, target=0x20, idx=0x00 -> PHT[0]=10, GHR=00001, branch_count_o=1. Next cycle pc_f_i=0x80 -> pht_index_o=0x01, PHT[1]=01, so predict_taken_o=0 despite BTB hit.
- Five taken updates to idx 3 -> counter 11 and stays 11. Then five not-taken -> 00 and stays 00. branch_count_o=10.
- Same-cycle jump update pc=0x40/target=0x200 with pc_f_i=0x40 -> that cycle target_o is the old 0x100 (or no hit); next cycle target_o=0x200.
- Assert reset between edges mid-run -> predict_taken_o=0, counters=0 and GHR=0 immediately; re-lookup of 0x40 misses.
